// File: rtl/video_timing_pipe_if.sv
// rtl/video_timing_pipe_if.sv - pixel-source and SDL/VGA output bundle of the video timing pipe
interface video_timing_pipe_if #(
    parameter int COLOR_W = 4,
    parameter int FRAME_W = 16
) ();
    logic               enable;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic [10:0]        h_coord;
    logic [9:0]         v_coord;
    logic               disp_enbl;
    logic               h_sync;
    logic               v_sync;
    logic [10:0]        sdl_sx;
    logic [9:0]         sdl_sy;
    logic               sdl_de;
    logic [7:0]         sdl_r;
    logic [7:0]         sdl_g;
    logic [7:0]         sdl_b;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_count;

    modport master (
        input  enable, red, green, blue,
        output h_coord, v_coord, disp_enbl, h_sync, v_sync,
               sdl_sx, sdl_sy, sdl_de, sdl_r, sdl_g, sdl_b,
               frame_start, frame_count
    );

    modport slave (
        output enable, red, green, blue,
        input  h_coord, v_coord, disp_enbl, h_sync, v_sync,
               sdl_sx, sdl_sy, sdl_de, sdl_r, sdl_g, sdl_b,
               frame_start, frame_count
    );
endinterface

// File: rtl/video_timing_pipe.sv
// rtl/video_timing_pipe.sv - video timing generator with source-latency alignment and SDL/VGA output stage
module video_timing_pipe #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int SYNC_POL = 1,
    parameter int COLOR_W  = 4,
    parameter int SRC_LAT  = 1,
    parameter int FRAME_W  = 16
) (
    input  logic                pixel_clk,
    input  logic                rst_n,
    video_timing_pipe_if.master vid
);
    localparam int H_T = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_T = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_T - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_T - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic       de;
        logic [9:0] y;
        logic [10:0] x;
    } pix_t;

    logic [10:0]        h_q, h_d;
    logic [9:0]         v_q, v_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;
    logic               h_last, v_last, frame_start;
    logic               disp_enbl, hs_act, vs_act;
    pix_t               cur_pix, dl_out;

    logic [10:0] sdl_sx_q, sdl_sx_d;
    logic [9:0]  sdl_sy_q, sdl_sy_d;
    logic        sdl_de_q, sdl_de_d;
    logic [7:0]  sdl_r_q, sdl_r_d;
    logic [7:0]  sdl_g_q, sdl_g_d;
    logic [7:0]  sdl_b_q, sdl_b_d;
    logic [7:0]  exp_r, exp_g, exp_b;

    assign h_last      = (h_q == H_LAST);
    assign v_last      = (v_q == V_LAST);
    assign frame_start = vid.enable && h_last && v_last;
    assign disp_enbl   = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_act      = (h_q >= HS_START) && (h_q < HS_END);
    assign vs_act      = (v_q >= VS_START) && (v_q < VS_END);

    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        frame_count_d = frame_count_q;
        if (vid.enable) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end
        if (frame_start) begin
            frame_count_d = frame_count_q + 1'b1;
        end
    end

    assign cur_pix = '{de: disp_enbl, y: v_q, x: h_q};

    // Coordinates wait here until the source's colour for them arrives.
    if (SRC_LAT > 0) begin : g_dl
        pix_t dl_q [SRC_LAT];
        pix_t dl_d [SRC_LAT];

        always_comb begin
            for (int i = 0; i < SRC_LAT; i++) begin
                dl_d[i] = dl_q[i];
            end
            if (vid.enable) begin
                dl_d[0] = cur_pix;
                for (int i = 1; i < SRC_LAT; i++) begin
                    dl_d[i] = dl_q[i-1];
                end
            end
        end

        always_ff @(posedge pixel_clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < SRC_LAT; i++) begin
                    dl_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < SRC_LAT; i++) begin
                    dl_q[i] <= dl_d[i];
                end
            end
        end

        assign dl_out = dl_q[SRC_LAT-1];
    end else begin : g_nodl
        assign dl_out = cur_pix;
    end

    // Each output bit repeats the input MSB-first, so full scale maps to 8'hFF.
    for (genvar i = 0; i < 8; i++) begin : g_exp
        localparam int SRC_BIT = COLOR_W - 1 - ((7 - i) % COLOR_W);
        assign exp_r[i] = vid.red[SRC_BIT];
        assign exp_g[i] = vid.green[SRC_BIT];
        assign exp_b[i] = vid.blue[SRC_BIT];
    end

    always_comb begin
        sdl_sx_d = sdl_sx_q;
        sdl_sy_d = sdl_sy_q;
        sdl_de_d = sdl_de_q;
        sdl_r_d  = sdl_r_q;
        sdl_g_d  = sdl_g_q;
        sdl_b_d  = sdl_b_q;
        if (vid.enable) begin
            sdl_sx_d = dl_out.x;
            sdl_sy_d = dl_out.y;
            sdl_de_d = dl_out.de;
            sdl_r_d  = dl_out.de ? exp_r : 8'h00;
            sdl_g_d  = dl_out.de ? exp_g : 8'h00;
            sdl_b_d  = dl_out.de ? exp_b : 8'h00;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            frame_count_q <= '0;
            sdl_sx_q      <= '0;
            sdl_sy_q      <= '0;
            sdl_de_q      <= 1'b0;
            sdl_r_q       <= '0;
            sdl_g_q       <= '0;
            sdl_b_q       <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            frame_count_q <= frame_count_d;
            sdl_sx_q      <= sdl_sx_d;
            sdl_sy_q      <= sdl_sy_d;
            sdl_de_q      <= sdl_de_d;
            sdl_r_q       <= sdl_r_d;
            sdl_g_q       <= sdl_g_d;
            sdl_b_q       <= sdl_b_d;
        end
    end

    assign vid.h_coord     = h_q;
    assign vid.v_coord     = v_q;
    assign vid.disp_enbl   = disp_enbl;
    assign vid.h_sync      = (SYNC_POL != 0) ? hs_act : ~hs_act;
    assign vid.v_sync      = (SYNC_POL != 0) ? vs_act : ~vs_act;
    assign vid.sdl_sx      = sdl_sx_q;
    assign vid.sdl_sy      = sdl_sy_q;
    assign vid.sdl_de      = sdl_de_q;
    assign vid.sdl_r       = sdl_r_q;
    assign vid.sdl_g       = sdl_g_q;
    assign vid.sdl_b       = sdl_b_q;
    assign vid.frame_start = frame_start;
    assign vid.frame_count = frame_count_q;
endmodule

// File: tb/tb_video_timing_pipe.sv
// tb/tb_video_timing_pipe.sv - self-checking bench for video_timing_pipe against a frame-position reference model
module tb_video_timing_pipe;
    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, pol, w, l;
    } cfg_t;

    typedef struct {
        int h, v, de, hs, vs, sx, sy, sde, r, g, b, fs, fc;
    } obs_t;

    typedef struct {
        logic [7:0] cin;
        logic [7:0] e4;
        logic [7:0] e5;
        logic [7:0] e8;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    video_timing_pipe_if #(.COLOR_W(4), .FRAME_W(16)) ia ();
    video_timing_pipe_if #(.COLOR_W(5), .FRAME_W(16)) ib ();
    video_timing_pipe_if #(.COLOR_W(8), .FRAME_W(16)) ic ();

    video_timing_pipe #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1), .COLOR_W(4), .SRC_LAT(2), .FRAME_W(16)
    ) u_a (.pixel_clk(clk), .rst_n(rst_n), .vid(ia));

    video_timing_pipe #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0), .COLOR_W(5), .SRC_LAT(0), .FRAME_W(16)
    ) u_b (.pixel_clk(clk), .rst_n(rst_n), .vid(ib));

    video_timing_pipe #(
        .SYNC_POL(1), .COLOR_W(8), .SRC_LAT(7), .FRAME_W(16)
    ) u_c (.pixel_clk(clk), .rst_n(rst_n), .vid(ic));

    always #5 clk = ~clk;

    cfg_t ca, cb, cc;
    int   n;
    bit   en;
    int   lc  [3][3];
    int   cur [3][3];
    int   checks = 0;
    int   fails  = 0;
    vec_t vecs [6];

    // Repeat the code end to end and keep the leading 8 bits.
    function automatic int expand(int c, int w);
        int rep;
        int bits;
        rep  = 0;
        bits = 0;
        while (bits < 8) begin
            rep  = (rep << w) | c;
            bits = bits + w;
        end
        return (rep >> (bits - 8)) & 255;
    endfunction

    function automatic obs_t model(cfg_t c, int k, bit e, int cr, int cg, int cbl);
        obs_t o;
        int ht, vt, tot, p, q, idx;
        bit hsa, vsa;
        ht  = c.ha + c.hfp + c.hs + c.hbp;
        vt  = c.va + c.vfp + c.vs + c.vbp;
        tot = ht * vt;
        p   = k % tot;
        o.h = p % ht;
        o.v = p / ht;
        o.de = (o.h < c.ha && o.v < c.va) ? 1 : 0;
        hsa = (o.h >= c.ha + c.hfp) && (o.h < c.ha + c.hfp + c.hs);
        vsa = (o.v >= c.va + c.vfp) && (o.v < c.va + c.vfp + c.vs);
        o.hs = ((c.pol != 0) ? hsa : !hsa) ? 1 : 0;
        o.vs = ((c.pol != 0) ? vsa : !vsa) ? 1 : 0;
        o.fs = (e && p == tot - 1) ? 1 : 0;
        o.fc = (k / tot) % 65536;
        idx = k - 1 - c.l;
        if (idx < 0) begin
            o.sx  = 0;
            o.sy  = 0;
            o.sde = 0;
        end else begin
            q     = idx % tot;
            o.sx  = q % ht;
            o.sy  = q / ht;
            o.sde = (o.sx < c.ha && o.sy < c.va) ? 1 : 0;
        end
        o.r = (o.sde != 0) ? expand(cr, c.w) : 0;
        o.g = (o.sde != 0) ? expand(cg, c.w) : 0;
        o.b = (o.sde != 0) ? expand(cbl, c.w) : 0;
        return o;
    endfunction

    task automatic cmp(string tag, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at n=%0d: actual=%0d expected=%0d", tag, n, act, exp);
        end
    endtask

    task automatic cmp_obs(string inst, obs_t a, obs_t e);
        cmp({inst, ".h_coord"},     a.h,   e.h);
        cmp({inst, ".v_coord"},     a.v,   e.v);
        cmp({inst, ".disp_enbl"},   a.de,  e.de);
        cmp({inst, ".h_sync"},      a.hs,  e.hs);
        cmp({inst, ".v_sync"},      a.vs,  e.vs);
        cmp({inst, ".sdl_sx"},      a.sx,  e.sx);
        cmp({inst, ".sdl_sy"},      a.sy,  e.sy);
        cmp({inst, ".sdl_de"},      a.sde, e.sde);
        cmp({inst, ".sdl_r"},       a.r,   e.r);
        cmp({inst, ".sdl_g"},       a.g,   e.g);
        cmp({inst, ".sdl_b"},       a.b,   e.b);
        cmp({inst, ".frame_start"}, a.fs,  e.fs);
        cmp({inst, ".frame_count"}, a.fc,  e.fc);
    endtask

    task automatic check_all();
        obs_t oa, ob, oc;
        oa = '{int'(ia.h_coord), int'(ia.v_coord), int'(ia.disp_enbl), int'(ia.h_sync),
               int'(ia.v_sync), int'(ia.sdl_sx), int'(ia.sdl_sy), int'(ia.sdl_de),
               int'(ia.sdl_r), int'(ia.sdl_g), int'(ia.sdl_b), int'(ia.frame_start),
               int'(ia.frame_count)};
        ob = '{int'(ib.h_coord), int'(ib.v_coord), int'(ib.disp_enbl), int'(ib.h_sync),
               int'(ib.v_sync), int'(ib.sdl_sx), int'(ib.sdl_sy), int'(ib.sdl_de),
               int'(ib.sdl_r), int'(ib.sdl_g), int'(ib.sdl_b), int'(ib.frame_start),
               int'(ib.frame_count)};
        oc = '{int'(ic.h_coord), int'(ic.v_coord), int'(ic.disp_enbl), int'(ic.h_sync),
               int'(ic.v_sync), int'(ic.sdl_sx), int'(ic.sdl_sy), int'(ic.sdl_de),
               int'(ic.sdl_r), int'(ic.sdl_g), int'(ic.sdl_b), int'(ic.frame_start),
               int'(ic.frame_count)};
        cmp_obs("a", oa, model(ca, n, en, lc[0][0], lc[0][1], lc[0][2]));
        cmp_obs("b", ob, model(cb, n, en, lc[1][0], lc[1][1], lc[1][2]));
        cmp_obs("c", oc, model(cc, n, en, lc[2][0], lc[2][1], lc[2][2]));
    endtask

    task automatic set_enable(bit e);
        en        = e;
        ia.enable = e;
        ib.enable = e;
        ic.enable = e;
    endtask

    task automatic drive_colours();
        ia.red = 4'(cur[0][0]); ia.green = 4'(cur[0][1]); ia.blue = 4'(cur[0][2]);
        ib.red = 5'(cur[1][0]); ib.green = 5'(cur[1][1]); ib.blue = 5'(cur[1][2]);
        ic.red = 8'(cur[2][0]); ic.green = 8'(cur[2][1]); ic.blue = 8'(cur[2][2]);
    endtask

    // One pixel clock: drive at the falling edge, check just after, then advance the model.
    task automatic cycle(bit e, bit fixed, int cin);
        int w [3];
        w = '{4, 5, 8};
        @(negedge clk);
        set_enable(e);
        for (int i = 0; i < 3; i++) begin
            for (int ch = 0; ch < 3; ch++) begin
                cur[i][ch] = (fixed ? cin : int'($urandom)) & ((1 << w[i]) - 1);
            end
        end
        drive_colours();
        #1;
        check_all();
        @(posedge clk);
        if (e) begin
            n++;
            lc = cur;
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        set_enable(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            for (int ch = 0; ch < 3; ch++) begin
                lc[i][ch] = 0;
            end
        end
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        obs_t mexp;
        ca = '{8, 2, 3, 2, 6, 1, 2, 1, 1, 4, 2};
        cb = '{8, 2, 3, 2, 6, 1, 2, 1, 0, 5, 0};
        cc = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 8, 7};
        vecs[0] = '{8'h16, 8'h66, 8'hB5, 8'h16};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{8'h81, 8'h11, 8'h08, 8'h81};
        vecs[4] = '{8'h39, 8'h99, 8'hCE, 8'h39};
        vecs[5] = '{8'hA5, 8'h55, 8'h29, 8'hA5};

        n = 0;
        for (int i = 0; i < 3; i++) begin
            for (int ch = 0; ch < 3; ch++) begin
                lc[i][ch]  = 0;
                cur[i][ch] = 0;
            end
        end
        rst_n = 1'b0;
        set_enable(1'b0);
        drive_colours();
        #12;
        check_all();
        cmp("reset a.h_sync",      int'(ia.h_sync),      0);
        cmp("reset b.h_sync",      int'(ib.h_sync),      1);
        cmp("reset b.v_sync",      int'(ib.v_sync),      1);
        cmp("reset a.disp_enbl",   int'(ia.disp_enbl),   1);
        cmp("reset c.frame_count", int'(ic.frame_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, int'(vecs[i].cin));
            #1;
            mexp = model(ca, n, 1'b1, lc[0][0], lc[0][1], lc[0][2]);
            cmp("tbl a.sdl_g", int'(ia.sdl_g), (mexp.sde != 0) ? int'(vecs[i].e4) : 0);
            mexp = model(cb, n, 1'b1, lc[1][0], lc[1][1], lc[1][2]);
            cmp("tbl b.sdl_g", int'(ib.sdl_g), (mexp.sde != 0) ? int'(vecs[i].e5) : 0);
            mexp = model(cc, n, 1'b1, lc[2][0], lc[2][1], lc[2][2]);
            cmp("tbl c.sdl_g", int'(ic.sdl_g), (mexp.sde != 0) ? int'(vecs[i].e8) : 0);
        end

        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 0);
        async_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 15);

        for (int i = 0; i < 1800; i++) begin
            cycle(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, 1'b0, 0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
